rv32_wb_arbiter: RTL and testbench
==================================

# rv32_wb_arbiter

Write-port arbiter and pending-write scoreboard for the rv32 integer register file. The regfile has a single write port. This block shares it between the in-order pipeline writeback and a long-latency unit (load/mul/div return path), and drives the regfile write signals from a registered stage. It also tracks which architectural registers have outstanding long-latency writes so the issue stage can stall on RAW hazards.

## Interface
Parameters:
- XPR_LEN, 32: data width; matches `XPR_LEN`.
- REG_ADDR_WIDTH, 5: register address width; matches `REG_ADDR_WIDTH`.
- STARVE_LIMIT, 4: number of consecutive cycles the LU may wait before it is force-granted; legal range 1..15.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- wb_valid  in  1  pipeline writeback request.
- wb_ready  out  1  pipeline writeback grant; combinational.
- wb_rd  in  REG_ADDR_WIDTH  pipeline destination register.
- wb_data  in  XPR_LEN  pipeline write data.
- lu_valid  in  1  long-latency unit request; must be held until the handshake.
- lu_ready  out  1  LU grant; combinational.
- lu_rd  in  REG_ADDR_WIDTH  LU destination register.
- lu_data  in  XPR_LEN  LU write data.
- sb_set  in  1  issue stage marks sb_set_rd as pending a long-latency write.
- sb_set_rd  in  REG_ADDR_WIDTH  register to mark busy.
- rs1_addr, rs2_addr  in  REG_ADDR_WIDTH each  scoreboard query addresses.
- rs1_busy, rs2_busy  out  1 each  combinational from busy bits.
- sb_conflict  out  1  registered one-cycle pulse: sb_set targeted an already-busy register.
- rf_wen  out  1  registered regfile write enable.
- rf_wa  out  REG_ADDR_WIDTH  registered regfile write address.
- rf_wd  out  XPR_LEN  registered regfile write data.

## Operation
- Handshake: a transfer occurs when valid && ready in the same cycle. At most one transfer per cycle.
- FSM states:
  - NORMAL: wb_ready=1 and lu_ready=!wb_valid.
  - FORCE_LU: wb_ready=0 and lu_ready=1.
- Starve counter, width $clog2(STARVE_LIMIT+1):
  - In NORMAL, it increments each cycle lu_valid && !lu_ready.
  - It clears on any LU handshake.
  - When lu_valid && !lu_ready and the counter equals STARVE_LIMIT-1, the next state is FORCE_LU.
- In FORCE_LU:
  - An LU handshake returns to NORMAL and clears the counter.
  - If lu_valid drops (protocol violation), the FSM returns to NORMAL and the counter clears.
- Winning transfer: on the next edge, rf_wen=1 and rf_wa/rf_wd take the winner's rd/data. With no transfer, rf_wen=0 and rf_wa/rf_wd hold their values.
- Writes with rd=0 are still forwarded; the regfile discards them.
- Scoreboard: 32 busy bits, with bit 0 hardwired to 0.
  - Set: sb_set && sb_set_rd!=0 sets busy[sb_set_rd].
  - Clear: at the edge where rf_wen=1 is sampled, busy[rf_wa] is cleared.
  - A clear applies to both WB- and LU-sourced writes.
  - Set and clear of the same register in the same cycle: set wins.
- sb_conflict: asserted the cycle after sb_set hits a register already busy and not being cleared that cycle. The set still takes effect.
- rsN_busy = busy[rsN_addr]; address 0 always returns 0.

## Timing
- Reset (async assert, sync release):
  - rf_wen=0, rf_wa=0, rf_wd=0, sb_conflict=0.
  - All busy bits 0, state NORMAL, counter 0.
  - wb_ready=1, lu_ready=!wb_valid.
- Reset mid-operation discards any registered write and all pending marks.
- Latency:
  - Handshake in cycle N gives rf_wen in N+1.
  - Data is readable from the regfile in N+2.
  - The busy bit clears at the end of N+1, so rsN_busy=0 from N+2.
- Worst-case LU wait under continuous wb_valid is STARVE_LIMIT cycles before grant. During the grant cycle, wb_ready=0 and the pipeline stalls.
- Back-to-back transfers: one per cycle, with no bubbles.

## Structure
- XPR_LEN, REG_ADDR_WIDTH and the FSM state enum (NORMAL, FORCE_LU) belong in the shared rv32 defines/package.
- One sub-module: rv32_scoreboard. It holds the 32 busy bits and has set/clear/query ports and the conflict flag.
- The arbiter FSM, starve counter and output register stay in rv32_wb_arbiter.

## Test plan
- Reset: assert rst_n=0 mid-transfer → rf_wen=0, all busy=0, wb_ready=1 immediately (asynchronous).
- WB only: wb_valid=1, wb_rd=5, wb_data=0xDEADBEEF → next cycle rf_wen=1, rf_wa=5, rf_wd=0xDEADBEEF.
- LU starvation, STARVE_LIMIT=4: wb_valid held high, lu_valid=1, lu_rd=7, lu_data=0x1234 from cycle 0 →
  - LU granted in cycle 4 with wb_ready=0.
  - rf_wa=7 in cycle 5.
  - wb_ready=1 again in cycle 5.
- Scoreboard: sb_set rd=9, then LU writes rd=9 while rs1_addr=9 →
  - rs1_busy=1 until the rf_wen cycle.
  - rs1_busy=0 the cycle after.
- Simultaneous events: sb_set rd=3 in the same cycle rf_wen=1, rf_wa=3 → busy[3] stays 1. Separately, sb_set rd=0 → rs1_busy(0)=0 and no sb_conflict.
- Conflict: sb_set rd=4 twice with no intervening write → sb_conflict=1 for exactly one cycle after the second set.

Source files
------------

// File: rtl/rv32_wb_arbiter_pkg.sv
// Shared rv32 widths, arbiter FSM state encodings and the regfile write record.
package rv32_wb_arbiter_pkg;

  localparam int XPR_LEN        = 32;
  localparam int REG_ADDR_WIDTH = 5;

  localparam logic [0:0] NORMAL   = 1'b0;
  localparam logic [0:0] FORCE_LU = 1'b1;

  typedef struct packed {
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [XPR_LEN-1:0]        data;
  } wr_t;

endpackage

// File: rtl/rv32_scoreboard.sv
// Pending long-latency write bits per architectural register; registered conflict flag.
// Set beats clear on the same register; queries are combinational; register 0 is never busy.
module rv32_scoreboard #(
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_set,
  input  logic [REG_ADDR_WIDTH-1:0] i_set_rd,
  input  logic                      i_clr,
  input  logic [REG_ADDR_WIDTH-1:0] i_clr_rd,
  input  logic [REG_ADDR_WIDTH-1:0] i_rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] i_rs2_addr,
  output logic                      o_rs1_busy,
  output logic                      o_rs2_busy,
  output logic                      o_conflict
);

  localparam int NREGS = 1 << REG_ADDR_WIDTH;

  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_busy_nxt;
  logic             r_conflict;
  logic             w_set;
  logic             w_conflict_nxt;

  always_comb begin
    w_set      = i_set && (i_set_rd != '0);
    w_busy_nxt = r_busy;
    if (i_clr) w_busy_nxt[i_clr_rd] = 1'b0;
    if (w_set) w_busy_nxt[i_set_rd] = 1'b1;
    w_busy_nxt[0] = 1'b0;
    // A register retiring this very cycle is a legitimate reuse, not a conflict.
    w_conflict_nxt = w_set && r_busy[i_set_rd] && !(i_clr && (i_clr_rd == i_set_rd));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_busy     <= '0;
      r_conflict <= 1'b0;
    end else begin
      r_busy     <= w_busy_nxt;
      r_conflict <= w_conflict_nxt;
    end
  end

  assign o_rs1_busy = r_busy[i_rs1_addr];
  assign o_rs2_busy = r_busy[i_rs2_addr];
  assign o_conflict = r_conflict;

endmodule

// File: rtl/rv32_wb_arbiter.sv
// Shares the regfile write port between pipeline writeback and the long-latency unit.
// One transfer per cycle, registered one cycle later; LU force-granted after STARVE_LIMIT waits.
module rv32_wb_arbiter #(
  parameter int XPR_LEN        = rv32_wb_arbiter_pkg::XPR_LEN,
  parameter int REG_ADDR_WIDTH = rv32_wb_arbiter_pkg::REG_ADDR_WIDTH,
  parameter int STARVE_LIMIT   = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_wb_valid,
  output logic                      o_wb_ready,
  input  logic [REG_ADDR_WIDTH-1:0] i_wb_rd,
  input  logic [XPR_LEN-1:0]        i_wb_data,
  input  logic                      i_lu_valid,
  output logic                      o_lu_ready,
  input  logic [REG_ADDR_WIDTH-1:0] i_lu_rd,
  input  logic [XPR_LEN-1:0]        i_lu_data,
  input  logic                      i_sb_set,
  input  logic [REG_ADDR_WIDTH-1:0] i_sb_set_rd,
  input  logic [REG_ADDR_WIDTH-1:0] i_rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] i_rs2_addr,
  output logic                      o_rs1_busy,
  output logic                      o_rs2_busy,
  output logic                      o_sb_conflict,
  output logic                      o_rf_wen,
  output logic [REG_ADDR_WIDTH-1:0] o_rf_wa,
  output logic [XPR_LEN-1:0]        o_rf_wd
);

  import rv32_wb_arbiter_pkg::*;

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [XPR_LEN-1:0]        data;
  } req_t;

  logic [0:0]                r_state;
  logic [0:0]                w_state_nxt;
  logic [CW-1:0]             r_cnt;
  logic [CW-1:0]             w_cnt_nxt;
  logic                      w_wb_ready;
  logic                      w_lu_ready;
  logic                      w_wb_fire;
  logic                      w_lu_fire;
  req_t                      w_win;
  logic                      r_rf_wen;
  logic [REG_ADDR_WIDTH-1:0] r_rf_wa;
  logic [XPR_LEN-1:0]        r_rf_wd;

  assign w_wb_ready = (r_state == NORMAL);
  assign w_lu_ready = (r_state == FORCE_LU) || !i_wb_valid;
  assign w_wb_fire  = i_wb_valid && w_wb_ready;
  assign w_lu_fire  = i_lu_valid && w_lu_ready;
  assign w_win      = w_lu_fire ? req_t'{rd: i_lu_rd, data: i_lu_data}
                                : req_t'{rd: i_wb_rd, data: i_wb_data};

  // FORCE_LU lasts exactly one cycle: the LU either transfers or has illegally dropped valid.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (r_state == FORCE_LU) begin
      w_state_nxt = NORMAL;
      w_cnt_nxt   = '0;
    end else if (w_lu_fire) begin
      w_cnt_nxt = '0;
    end else if (i_lu_valid) begin
      w_cnt_nxt = r_cnt + 1'b1;
      if (r_cnt == CW'(STARVE_LIMIT - 1)) w_state_nxt = FORCE_LU;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= NORMAL;
      r_cnt    <= '0;
      r_rf_wen <= 1'b0;
      r_rf_wa  <= '0;
      r_rf_wd  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_rf_wen <= w_wb_fire || w_lu_fire;
      if (w_wb_fire || w_lu_fire) begin
        r_rf_wa <= w_win.rd;
        r_rf_wd <= w_win.data;
      end
    end
  end

  rv32_scoreboard #(
    .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
  ) u_sb (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_set      (i_sb_set),
    .i_set_rd   (i_sb_set_rd),
    .i_clr      (r_rf_wen),
    .i_clr_rd   (r_rf_wa),
    .i_rs1_addr (i_rs1_addr),
    .i_rs2_addr (i_rs2_addr),
    .o_rs1_busy (o_rs1_busy),
    .o_rs2_busy (o_rs2_busy),
    .o_conflict (o_sb_conflict)
  );

  assign o_wb_ready = w_wb_ready;
  assign o_lu_ready = w_lu_ready;
  assign o_rf_wen   = r_rf_wen;
  assign o_rf_wa    = r_rf_wa;
  assign o_rf_wd    = r_rf_wd;

endmodule

// File: tb/tb_rv32_wb_arbiter.sv
// Directed bench for rv32_wb_arbiter: expected regfile writes are queued when driven
// and popped when rf_wen appears; other checks compare against bench-derived constants.
module tb_rv32_wb_arbiter;
  import rv32_wb_arbiter_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        wb_valid, wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        lu_valid, lu_ready;
  logic [4:0]  lu_rd;
  logic [31:0] lu_data;
  logic        sb_set;
  logic [4:0]  sb_set_rd;
  logic [4:0]  rs1_addr, rs2_addr;
  logic        rs1_busy, rs2_busy;
  logic        sb_conflict;
  logic        rf_wen;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;

  int  n_assert = 0;
  int  n_fail   = 0;
  wr_t exp_q[$];
  wr_t mon_e;

  rv32_wb_arbiter #(
    .XPR_LEN(32), .REG_ADDR_WIDTH(5), .STARVE_LIMIT(4)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_wb_valid(wb_valid), .o_wb_ready(wb_ready), .i_wb_rd(wb_rd), .i_wb_data(wb_data),
    .i_lu_valid(lu_valid), .o_lu_ready(lu_ready), .i_lu_rd(lu_rd), .i_lu_data(lu_data),
    .i_sb_set(sb_set), .i_sb_set_rd(sb_set_rd),
    .i_rs1_addr(rs1_addr), .i_rs2_addr(rs2_addr),
    .o_rs1_busy(rs1_busy), .o_rs2_busy(rs2_busy), .o_sb_conflict(sb_conflict),
    .o_rf_wen(rf_wen), .o_rf_wa(rf_wa), .o_rf_wd(rf_wd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic exp_push(input logic [4:0] rd, input logic [31:0] d);
    wr_t e;
    e.rd   = rd;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Every observed regfile write must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rf_wen === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("rf_unexpected_write", 64'(rf_wa), 64'h7fff);
      end else begin
        mon_e = exp_q.pop_front();
        chk("sb_rf_wa", 64'(rf_wa), 64'(mon_e.rd));
        chk("sb_rf_wd", 64'(rf_wd), 64'(mon_e.data));
      end
    end
  end

  initial begin
    rst_n = 1'b0; wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
    lu_valid = 1'b0; lu_rd = '0; lu_data = '0;
    sb_set = 1'b0; sb_set_rd = '0; rs1_addr = '0; rs2_addr = '0;

    // Reset state
    #2;
    chk("rst_rf_wen", rf_wen, 0);
    chk("rst_rf_wa", rf_wa, 0);
    chk("rst_rf_wd", rf_wd, 0);
    chk("rst_conflict", sb_conflict, 0);
    chk("rst_wb_ready", wb_ready, 1);
    chk("rst_lu_ready_idle", lu_ready, 1);
    wb_valid = 1'b1;
    #1 chk("rst_lu_ready_wbv", lu_ready, 0);
    wb_valid = 1'b0;
    tick; tick;
    rst_n = 1'b1;

    // WB-only write
    tick;
    wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF;
    exp_push(5'd5, 32'hDEADBEEF);
    #1;
    chk("wb_ready", wb_ready, 1);
    chk("wb_lu_ready", lu_ready, 0);
    tick;
    wb_valid = 1'b0;
    chk("wb_rf_wen", rf_wen, 1);
    chk("wb_rf_wa", rf_wa, 5);
    chk("wb_rf_wd", rf_wd, 32'hDEADBEEF);
    tick;
    chk("idle_rf_wen", rf_wen, 0);
    chk("idle_rf_wa_hold", rf_wa, 5);
    chk("idle_rf_wd_hold", rf_wd, 32'hDEADBEEF);

    // LU starvation: WB wins cycles 0..3, LU forced in cycle 4
    wb_valid = 1'b1; wb_rd = 5'd1; lu_valid = 1'b1; lu_rd = 5'd7; lu_data = 32'h1234;
    for (int c = 0; c < 4; c++) begin
      wb_data = 32'h100 + 32'(c);
      exp_push(5'd1, wb_data);
      #1;
      chk("starve_lu_wait", lu_ready, 0);
      chk("starve_wb_ready", wb_ready, 1);
      tick;
    end
    exp_push(5'd7, 32'h1234);
    #1;
    chk("force_wb_ready", wb_ready, 0);
    chk("force_lu_ready", lu_ready, 1);
    tick;
    lu_valid = 1'b0; wb_data = 32'h105;
    exp_push(5'd1, 32'h105);
    chk("force_rf_wa", rf_wa, 7);
    chk("force_rf_wd", rf_wd, 32'h1234);
    #1 chk("post_force_wb_ready", wb_ready, 1);
    tick;
    wb_valid = 1'b0;
    tick;
    chk("starve_queue_empty", 64'(exp_q.size()), 0);

    // Scoreboard set, then LU write retires it
    sb_set = 1'b1; sb_set_rd = 5'd9; rs1_addr = 5'd9; rs2_addr = 5'd0;
    tick;
    sb_set = 1'b0;
    chk("sb_first_set_no_conflict", sb_conflict, 0);
    #1;
    chk("sb_rs1_busy_set", rs1_busy, 1);
    chk("sb_rs2_zero", rs2_busy, 0);
    lu_valid = 1'b1; lu_rd = 5'd9; lu_data = 32'hCAFE;
    exp_push(5'd9, 32'hCAFE);
    #1;
    chk("sb_lu_ready", lu_ready, 1);
    chk("sb_busy_handshake", rs1_busy, 1);
    tick;
    lu_valid = 1'b0;
    chk("sb_rf_wen", rf_wen, 1);
    #1 chk("sb_busy_wen_cycle", rs1_busy, 1);
    tick;
    #1 chk("sb_busy_cleared", rs1_busy, 0);

    // Set and clear of the same register in one cycle: set wins
    tick;
    sb_set = 1'b1; sb_set_rd = 5'd3;
    tick;
    sb_set = 1'b0; wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h33;
    exp_push(5'd3, 32'h33);
    tick;
    wb_valid = 1'b0; sb_set = 1'b1; sb_set_rd = 5'd3; rs1_addr = 5'd3;
    chk("sim_rf_wen", rf_wen, 1);
    chk("sim_rf_wa", rf_wa, 3);
    tick;
    sb_set = 1'b0;
    chk("sim_no_conflict", sb_conflict, 0);
    #1 chk("sim_set_wins", rs1_busy, 1);

    // Setting x0 is ignored
    sb_set = 1'b1; sb_set_rd = 5'd0; rs1_addr = 5'd0;
    tick;
    sb_set = 1'b0;
    chk("x0_no_conflict", sb_conflict, 0);
    #1 chk("x0_not_busy", rs1_busy, 0);

    // Double set without an intervening write
    tick;
    sb_set = 1'b1; sb_set_rd = 5'd4; rs2_addr = 5'd4;
    tick;
    chk("conf_first_set", sb_conflict, 0);
    #1 chk("conf_rs2_busy", rs2_busy, 1);
    tick;
    sb_set = 1'b0;
    chk("conf_pulse", sb_conflict, 1);
    tick;
    chk("conf_one_cycle", sb_conflict, 0);

    // Asynchronous reset while in FORCE_LU with a registered write pending
    wb_valid = 1'b1; wb_rd = 5'd10; wb_data = 32'hA0;
    lu_valid = 1'b1; lu_rd = 5'd11; lu_data = 32'hB0;
    for (int c = 0; c < 3; c++) begin
      exp_push(5'd10, 32'hA0);
      tick;
    end
    tick;
    chk("rst_pre_rf_wen", rf_wen, 1);
    #1 chk("rst_pre_force", wb_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("arst_rf_wen", rf_wen, 0);
    chk("arst_rf_wa", rf_wa, 0);
    chk("arst_rf_wd", rf_wd, 0);
    chk("arst_wb_ready", wb_ready, 1);
    chk("arst_lu_ready", lu_ready, 0);
    chk("arst_busy4", rs2_busy, 0);
    rs1_addr = 5'd3;
    #1 chk("arst_busy3", rs1_busy, 0);
    tick;
    wb_valid = 1'b0; lu_valid = 1'b0;
    rst_n = 1'b1;
    tick; tick;
    chk("final_rf_wen", rf_wen, 0);
    chk("final_queue_empty", 64'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
